// File: rtl/cordic_sincos_ctrl.sv
// Iterative CORDIC sequencer: steps an external arctan ROM through 2**ADDR_WIDTH
// micro-rotations and returns saturated cos/sin/z. Define CORDIC_VECTOR_EN for vectoring mode.
module cordic_sincos_ctrl #(
    parameter int                           DATA_WIDTH = 16,
    parameter int                           ADDR_WIDTH = 4,
    parameter int                           GUARD      = 2,
    parameter logic signed [DATA_WIDTH-1:0] K_INIT     = 16'h26DD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mode,
    input  logic signed [DATA_WIDTH-1:0] angle_in,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    output logic        [ADDR_WIDTH-1:0] rom_addr,
    input  logic signed [DATA_WIDTH-1:0] rom_q,
    output logic                         busy,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] cos_out,
    output logic signed [DATA_WIDTH-1:0] sin_out,
    output logic signed [DATA_WIDTH-1:0] z_out
);
    localparam int                      ACC_W     = DATA_WIDTH + GUARD;
    localparam logic [ADDR_WIDTH-1:0]   LAST_ITER = '1;
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
        return {{GUARD{v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        iter_q, iter_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic signed [ACC_W-1:0]      x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [ACC_W-1:0]      x_sh, y_sh, rom_ext, x_step, y_step, z_step;
    logic signed [DATA_WIDTH-1:0] cos_q, cos_d, sin_q, sin_d, zo_q, zo_d;
    logic                         rot_neg;

`ifdef CORDIC_VECTOR_EN
    logic vec_q, vec_d;
`else
    logic unused_vec_inputs;
    assign unused_vec_inputs = ^{mode, x_in, y_in};
`endif

    // One micro-rotation from the current accumulators; rot_neg selects d = -1.
    always_comb begin
        x_sh    = x_q >>> iter_q;
        y_sh    = y_q >>> iter_q;
        rom_ext = sext(rom_q);
`ifdef CORDIC_VECTOR_EN
        rot_neg = vec_q ? ~y_q[ACC_W-1] : z_q[ACC_W-1];
`else
        rot_neg = z_q[ACC_W-1];
`endif
        if (rot_neg) begin
            x_step = x_q + y_sh;
            y_step = y_q - x_sh;
            z_step = z_q + rom_ext;
        end else begin
            x_step = x_q - y_sh;
            y_step = y_q + x_sh;
            z_step = z_q - rom_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        zo_d    = zo_q;
`ifdef CORDIC_VECTOR_EN
        vec_d   = vec_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                    iter_d  = '0;
                    busy_d  = 1'b1;
`ifdef CORDIC_VECTOR_EN
                    vec_d   = mode;
                    if (mode) begin
                        x_d = sext(x_in);
                        y_d = sext(y_in);
                        z_d = '0;
                    end else begin
                        x_d = sext(K_INIT);
                        y_d = '0;
                        z_d = sext(angle_in);
                    end
`else
                    x_d     = sext(K_INIT);
                    y_d     = '0;
                    z_d     = sext(angle_in);
`endif
                end
            end
            ITER: begin
                x_d = x_step;
                y_d = y_step;
                z_d = z_step;
                if (iter_q == LAST_ITER) begin
                    // Results of the final rotation go straight to the output registers.
                    state_d = DONE;
                    iter_d  = '0;
                    done_d  = 1'b1;
                    cos_d   = sat(x_step);
                    sin_d   = sat(y_step);
                    zo_d    = sat(z_step);
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
            zo_q    <= '0;
`ifdef CORDIC_VECTOR_EN
            vec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            zo_q    <= zo_d;
`ifdef CORDIC_VECTOR_EN
            vec_q   <= vec_d;
`endif
        end
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
    end

    assign rom_addr = iter_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cos_out  = cos_q;
    assign sin_out  = sin_q;
    assign z_out    = zo_q;
endmodule

// File: tb/tb_cordic_sincos_ctrl.sv
// Self-checking bench for cordic_sincos_ctrl: spec vectors, random ops against a model, corner sequences.
module tb_cordic_sincos_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;
`ifdef CORDIC_VECTOR_EN
    localparam bit VEC_BUILD = 1'b1;
`else
    localparam bit VEC_BUILD = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst, start, mode;
    logic signed [DW-1:0] angle_in, x_in, y_in, rom_q, cos_out, sin_out, z_out;
    logic        [AW-1:0] rom_addr;
    logic                 busy, done;

    int rom_tbl[16];
    int checks = 0;
    int errors = 0;

    cordic_sincos_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .angle_in(angle_in), .x_in(x_in), .y_in(y_in),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .busy(busy), .done(done),
        .cos_out(cos_out), .sin_out(sin_out), .z_out(z_out)
    );

    always #5 clk = ~clk;
    assign rom_q = 16'(rom_tbl[rom_addr]);

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int got, input int exp, input int tol);
        checks++;
        if (got > exp + tol || got < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, got, exp, tol);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference CORDIC over plain integers, iterating the textbook recurrences.
    task automatic model(input bit vec, input int a, input int xi, input int yi,
                         output int c, output int s, output int z);
        int x, y, zz, nx, ny;
        bit neg;
        if (vec) begin x = xi; y = yi; zz = 0; end
        else begin x = 9949; y = 0; zz = a; end
        for (int i = 0; i < 16; i++) begin
            neg = vec ? (y >= 0) : (zz < 0);
            if (neg) begin nx = x + (y >>> i); ny = y - (x >>> i); zz = zz + rom_tbl[i]; end
            else begin nx = x - (y >>> i); ny = y + (x >>> i); zz = zz - rom_tbl[i]; end
            x = nx;
            y = ny;
        end
        c = sat16(x);
        s = sat16(y);
        z = sat16(zz);
    endtask

    task automatic do_op(input int a, input bit m, input int xi, input int yi,
                         output int c, output int s, output int z,
                         output int lat, output bit seq_ok);
        angle_in = 16'(a); mode = m; x_in = 16'(xi); y_in = 16'(yi); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        angle_in = 16'($urandom); x_in = 16'($urandom); y_in = 16'($urandom); mode = ~m;
        lat = 1;
        seq_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (rom_addr != 4'(k) || !busy || done) seq_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        c = cos_out; s = sin_out; z = z_out;
        if (!busy) seq_ok = 1'b0;
        @(posedge clk); #1;
        if (busy || done) seq_ok = 1'b0;
    endtask

    typedef struct {
        logic signed [DW-1:0] angle;
        logic signed [DW-1:0] cos_e;
        logic signed [DW-1:0] sin_e;
    } vec_t;

    initial begin
        vec_t tbl[4];
        real  p;
        int   c, s, z, lat, mc, ms, mz, a, xi, yi, first, second, npulse, cnt;
        bit   seq_ok, m;

        p = 1.0;
        for (int i = 0; i < 16; i++) begin
            rom_tbl[i] = int'($atan(p) * 16384.0);
            p = p / 2.0;
        end
        tbl[0] = '{16'h0000, 16'h4000, 16'h0000};
        tbl[1] = '{16'h2182, 16'h376D, 16'h2000};
        tbl[2] = '{16'hCDBC, 16'h2D41, 16'hD2BF};
        tbl[3] = '{16'h6488, 16'h0000, 16'h4000};

        rst = 1'b1; start = 1'b0; mode = 1'b0; angle_in = '0; x_in = '0; y_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_cos", cos_out, 0);
        chk("rst_sin", sin_out, 0);
        chk("rst_z", z_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            do_op(tbl[t].angle, 1'b0, 0, 0, c, s, z, lat, seq_ok);
            model(1'b0, tbl[t].angle, 0, 0, mc, ms, mz);
            chk_tol($sformatf("tbl%0d_cos", t), c, tbl[t].cos_e, 8);
            chk_tol($sformatf("tbl%0d_sin", t), s, tbl[t].sin_e, 8);
            chk($sformatf("tbl%0d_cos_model", t), c, mc);
            chk($sformatf("tbl%0d_sin_model", t), s, ms);
            chk($sformatf("tbl%0d_z_model", t), z, mz);
            chk($sformatf("tbl%0d_latency", t), lat, 17);
            chk($sformatf("tbl%0d_sequence", t), seq_ok, 1);
        end

        for (int r = 0; r < 30; r++) begin
            if (r % 5 == 4) a = int'(16'($urandom)) - ((($urandom & 1) == 1) ? 65536 : 0);
            else a = int'($urandom_range(0, 51472)) - 25736;
            a = int'(16'(a));
            if (a > 32767) a = a - 65536;
            m  = 1'($urandom);
            xi = int'($urandom_range(1, 32767));
            yi = int'($urandom_range(0, 65535)) - 32768;
            do_op(a, m, xi, yi, c, s, z, lat, seq_ok);
            model(m && VEC_BUILD, a, xi, yi, mc, ms, mz);
            chk($sformatf("rnd%0d_cos", r), c, mc);
            chk($sformatf("rnd%0d_sin", r), s, ms);
            chk($sformatf("rnd%0d_z", r), z, mz);
            chk($sformatf("rnd%0d_latency", r), lat, 17);
            chk($sformatf("rnd%0d_sequence", r), seq_ok, 1);
        end

        // start held high through busy: two completions 18 cycles apart
        angle_in = 16'h6488; mode = 1'b0; start = 1'b1;
        first = -1; second = -1; npulse = 0; c = 0; s = 0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk); #1;
            if (done) begin
                npulse++;
                if (first < 0) begin first = e; c = cos_out; s = sin_out; end
                else if (second < 0) second = e;
            end
        end
        start = 1'b0;
        chk("held_pulses", npulse, 2);
        chk("held_first", first, 17);
        chk("held_gap", second - first, 18);
        chk_tol("held_cos", c, 0, 8);
        chk_tol("held_sin", s, 16384, 8);
        cnt = 0;
        while (busy && cnt < 40) begin @(posedge clk); #1; cnt++; end
        chk("held_drain", busy, 0);
        @(posedge clk); #1;

        // start re-asserted at iteration 3 with another angle must be ignored
        angle_in = 16'h2182; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_addr", rom_addr, 3);
        angle_in = 16'hCDBC; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        model(1'b0, 16'sh2182, 0, 0, mc, ms, mz);
        chk("mid_latency", lat, 17);
        chk("mid_cos", cos_out, mc);
        chk("mid_sin", sin_out, ms);
        chk("mid_z", z_out, mz);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("donecyc_busy", busy, 0);
        chk("donecyc_done", done, 0);
        cnt = 0;
        for (int e = 0; e < 20; e++) begin @(posedge clk); #1; if (done || busy) cnt++; end
        chk("donecyc_no_op", cnt, 0);

        // reset at iteration 5 aborts without a done pulse
        angle_in = 16'h1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("abort_addr5", rom_addr, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", rom_addr, 0);
        chk("abort_cos", cos_out, 0);
        chk("abort_sin", sin_out, 0);
        chk("abort_z", z_out, 0);
        rst = 1'b0;
        cnt = 0;
        for (int e = 0; e < 25; e++) begin @(posedge clk); #1; if (done) cnt++; end
        chk("abort_no_done", cnt, 0);

        do_op(16'h1000, 1'b1, 16'h2000, 16'h2000, c, s, z, lat, seq_ok);
        chk("vec_latency", lat, 17);
`ifdef CORDIC_VECTOR_EN
        chk_tol("vec_z", z, 16'h3244, 8);
        chk_tol("vec_cos", c, 16'h4A87, 8);
        chk_tol("vec_sin", s, 0, 8);
`else
        model(1'b0, 16'h1000, 0, 0, mc, ms, mz);
        chk("novec_cos", c, mc);
        chk("novec_sin", s, ms);
        chk("novec_z", z, mz);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
